// File: rtl/joybus_pkg.sv
// Shared JOYBUS definitions: FSM state type, command bytes and quarter-bit timing.
// Used by joybus_tx and joybus_qtick (and by the companion receiver).
package joybus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BIT_LOW,
    BIT_HIGH,
    STOP_LOW,
    STOP_HIGH
  } jb_tx_state_t;

  localparam logic [7:0] JB_CMD_INFO  = 8'h00;
  localparam logic [7:0] JB_CMD_POLL  = 8'h01;
  localparam logic [7:0] JB_CMD_READ  = 8'h02;
  localparam logic [7:0] JB_CMD_WRITE = 8'h03;
  localparam logic [7:0] JB_CMD_RESET = 8'hFF;

  localparam logic [1:0] Q_BIT0_LOW  = 2'd3;
  localparam logic [1:0] Q_BIT1_LOW  = 2'd1;
  localparam logic [1:0] Q_STOP_LOW  = 2'd1;
  localparam logic [1:0] Q_STOP_HIGH = 2'd2;
  localparam logic [2:0] Q_PER_BIT   = 3'd4;

  function automatic logic [1:0] bit_low_q(input logic b);
    return b ? Q_BIT1_LOW : Q_BIT0_LOW;
  endfunction

  // A data bit always spans four quarters, so the high phase is the remainder.
  function automatic logic [1:0] bit_high_q(input logic b);
    return 2'(Q_PER_BIT - {1'b0, bit_low_q(b)});
  endfunction

endpackage

// File: rtl/joybus_qtick.sv
// Quarter-bit tick generator: counts 0..CLK_PER_US-1 and pulses tick on the last count.
// Synchronous clear restarts the quarter; shared by the JOYBUS transmitter and receiver.
module joybus_qtick #(
  parameter int unsigned CLK_PER_US = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_PER_US - 1));

  // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/joybus_tx.sv
// Console-side JOYBUS transmitter: serializes a 1-3 byte command plus console stop bit.
// Optional macro JOYBUS_TX_RX_HANDOFF_EN adds an rx_start pulse coincident with tx_done.
module joybus_tx
  import joybus_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 25,
  parameter int unsigned MAX_BYTES  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_start,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  input  logic [1:0]             tx_len,
  output logic                   JB_TX,
  output logic                   tx_busy,
`ifdef JOYBUS_TX_RX_HANDOFF_EN
  output logic                   rx_start,
`endif
  output logic                   tx_done
);

  localparam int unsigned DW  = 8 * MAX_BYTES;
  localparam int unsigned BCW = $clog2(DW + 1);

  jb_tx_state_t   state, state_n;
  logic [DW-1:0]  sreg;
  logic [1:0]     len_q;
  logic [1:0]     qcnt;
  logic [1:0]     q_need;
  logic [BCW-1:0] bit_cnt;
  logic [BCW-1:0] bits_total;
  logic           tick, q_last, last_bit, cur_bit, accept, clr, jb_tx_q;

  assign cur_bit    = sreg[DW-1];
  assign bits_total = BCW'({len_q, 3'b000});
  assign last_bit   = (bit_cnt == bits_total - BCW'(1));
  assign accept     = (state == IDLE) && tx_start && (tx_len != 2'd0);

  // Hold the quarter timer at zero while idle so the first bit gets a full quarter.
  assign clr = (state == IDLE) || (state_n != state);

  joybus_qtick #(.CLK_PER_US(CLK_PER_US)) u_qtick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    // NOTE: defaults first so no path leaves q_need unassigned (no latch).
    q_need = 2'd1;
    case (state)
      BIT_LOW:   q_need = bit_low_q(cur_bit);
      BIT_HIGH:  q_need = bit_high_q(cur_bit);
      STOP_LOW:  q_need = Q_STOP_LOW;
      STOP_HIGH: q_need = Q_STOP_HIGH;
      default:   q_need = 2'd1;
    endcase
  end

  assign q_last = tick && (qcnt == q_need - 2'd1);

  always_comb begin
    state_n = state;
    tx_done = 1'b0;
    case (state)
      IDLE:      if (accept) state_n = BIT_LOW;
      BIT_LOW:   if (q_last) state_n = BIT_HIGH;
      BIT_HIGH:  if (q_last) state_n = last_bit ? STOP_LOW : BIT_LOW;
      STOP_LOW:  if (q_last) state_n = STOP_HIGH;
      STOP_HIGH: begin
        if (q_last) begin
          state_n = IDLE;
          tx_done = 1'b1;
        end
      end
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      len_q   <= '0;
      qcnt    <= '0;
      bit_cnt <= '0;
      jb_tx_q <= 1'b1;
    end else begin
      state   <= state_n;
      // Line level is decided from the next state so JB_TX is a clean flop output.
      jb_tx_q <= !((state_n == BIT_LOW) || (state_n == STOP_LOW));

      if (state_n != state) begin
        qcnt <= '0;
      end else if (tick && (state != IDLE)) begin
        qcnt <= qcnt + 2'd1;
      end

      if (accept) begin
        sreg    <= tx_data;
        len_q   <= tx_len;
        bit_cnt <= '0;
      end else if ((state == BIT_HIGH) && q_last && !last_bit) begin
        sreg    <= sreg << 1;
        bit_cnt <= bit_cnt + BCW'(1);
      end
    end
  end

  assign JB_TX   = jb_tx_q;
  assign tx_busy = (state != IDLE);

`ifdef JOYBUS_TX_RX_HANDOFF_EN
  assign rx_start = tx_done;
`endif

endmodule

// File: tb/tb_joybus_tx.sv
// Self-checking bench for joybus_tx: decodes the line by pulse width and compares
// against bit timings computed from the command bytes.
module tb_joybus_tx;

  localparam int C    = 25;
  localparam int MAXC = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_start;
  logic [23:0] tx_data;
  logic [1:0]  tx_len;
  logic        JB_TX, tx_busy, tx_done;
`ifdef JOYBUS_TX_RX_HANDOFF_EN
  logic        rx_start;
  int          rx_bad;
`endif

  int tests = 0;
  int fails = 0;

  int   lows_q[$];
  int   highs_q[$];
  int   frame_len;
  int   busy_bad;
  logic first_low;

  typedef struct {
    logic [23:0] data;
    logic [1:0]  len;
    bit          inject;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  joybus_tx #(.CLK_PER_US(C), .MAX_BYTES(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_len   (tx_len),
    .JB_TX    (JB_TX),
    .tx_busy  (tx_busy),
`ifdef JOYBUS_TX_RX_HANDOFF_EN
    .rx_start (rx_start),
`endif
    .tx_done  (tx_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic start_frame(input logic [23:0] data, input logic [1:0] len);
    @(negedge clk);
    tx_data  = data;
    tx_len   = len;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Records low/high run lengths from the first post-start sample until tx_done.
  task automatic capture(input bit inject, input logic [23:0] inj_data);
    logic lvl;
    int   run;
    lows_q.delete();
    highs_q.delete();
    frame_len = 0;
    busy_bad  = 0;
`ifdef JOYBUS_TX_RX_HANDOFF_EN
    rx_bad    = 0;
`endif
    first_low = JB_TX;
    lvl       = JB_TX;
    run       = 0;
    for (int n = 1; n <= MAXC; n++) begin
      if (n > 1) @(negedge clk);
      if (inject && n == 40) begin
        tx_data  = inj_data;
        tx_len   = 2'd3;
        tx_start = 1'b1;
      end
      if (inject && n == 41) tx_start = 1'b0;
      if (tx_busy !== 1'b1) busy_bad++;
`ifdef JOYBUS_TX_RX_HANDOFF_EN
      if (rx_start !== tx_done) rx_bad++;
`endif
      if (JB_TX !== lvl) begin
        if (lvl == 1'b0) lows_q.push_back(run);
        else             highs_q.push_back(run);
        lvl = JB_TX;
        run = 1;
      end else begin
        run++;
      end
      if (tx_done === 1'b1) begin
        if (lvl == 1'b0) lows_q.push_back(run);
        else             highs_q.push_back(run);
        frame_len = n;
        break;
      end
    end
  endtask

  // Expected widths come straight from the bit encoding: 1 = short low, 0 = long low.
  task automatic check_frame(input logic [23:0] data, input logic [1:0] len, input int exp_cycles);
    int          nb;
    int          bad;
    int          sl, sh;
    logic [23:0] dec;
    logic        b;
    nb  = 8 * int'(len);
    bad = 0;
    dec = '0;
    check("first_low", 32'(first_low), 32'd0);
    check("n_lows",  lows_q.size(),  nb + 1);
    check("n_highs", highs_q.size(), nb + 1);
    for (int i = 0; i < nb; i++) begin
      b = data[23-i];
      if (i < lows_q.size()) begin
        dec = {dec[22:0], (lows_q[i] == C)};
        if (lows_q[i] != (b ? C : 3 * C)) bad++;
      end
      if (i < highs_q.size() && highs_q[i] != (b ? 3 * C : C)) bad++;
    end
    check("decoded_data", 32'(dec), 32'(data >> (24 - nb)));
    check("bit_widths", bad, 0);
    sl = (lows_q.size()  > nb) ? lows_q[nb]  : -1;
    sh = (highs_q.size() > nb) ? highs_q[nb] : -1;
    check("stop_low",  sl, C);
    check("stop_high", sh, 2 * C);
    check("frame_cycles", frame_len, exp_cycles);
    check("busy_span", busy_bad, 0);
`ifdef JOYBUS_TX_RX_HANDOFF_EN
    check("rx_start_with_done", rx_bad, 0);
`endif
  endtask

  task automatic post_idle();
    @(negedge clk);
    check("done_one_cycle", 32'(tx_done), 32'd0);
    check("idle_busy", 32'(tx_busy), 32'd0);
    check("idle_line", 32'(JB_TX), 32'd1);
  endtask

  task automatic run_frame(input logic [23:0] data, input logic [1:0] len, input bit inject,
                           input int exp_cycles);
    start_frame(data, len);
    capture(inject, ~data);
    check_frame(data, len, exp_cycles);
    post_idle();
  endtask

  initial begin
    int          bad;
    logic [23:0] rd;
    logic [1:0]  rl;

    vecs[0] = '{data: 24'h01_00_00, len: 2'd1, inject: 1'b0, exp_cycles: 875};
    vecs[1] = '{data: 24'h02_80_15, len: 2'd3, inject: 1'b0, exp_cycles: 2475};
    vecs[2] = '{data: 24'h03_A5_00, len: 2'd2, inject: 1'b0, exp_cycles: 1675};
    vecs[3] = '{data: 24'hFF_00_00, len: 2'd1, inject: 1'b0, exp_cycles: 875};
    vecs[4] = '{data: 24'h00_C3_5A, len: 2'd3, inject: 1'b1, exp_cycles: 2475};

    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = '0;
    tx_len   = '0;
    repeat (3) @(negedge clk);
    check("reset_line", 32'(JB_TX), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_done", 32'(tx_done), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_frame(vecs[i].data, vecs[i].len, vecs[i].inject, vecs[i].exp_cycles);

    // Zero-length request must not start anything.
    start_frame(24'h01_00_00, 2'd0);
    bad = 0;
    for (int n = 0; n < 200; n++) begin
      if (JB_TX !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
      @(negedge clk);
    end
    check("len0_ignored", bad, 0);

    // Start coinciding with tx_done is dropped; held into the first idle cycle it is taken.
    start_frame(24'h01_00_00, 2'd1);
    capture(1'b0, '0);
    check_frame(24'h01_00_00, 2'd1, 875);
    tx_data  = 24'hA0_00_00;
    tx_len   = 2'd1;
    tx_start = 1'b1;
    post_idle();
    @(negedge clk);
    tx_start = 1'b0;
    capture(1'b0, '0);
    check_frame(24'hA0_00_00, 2'd1, 875);
    post_idle();

    // Reset during the bit-4 low phase aborts without a done pulse.
    start_frame(24'h0F_00_00, 2'd1);
    repeat (402) @(negedge clk);
    check("bit4_low_before_rst", 32'(JB_TX), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_line", 32'(JB_TX), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (JB_TX !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    check("rst_quiet", bad, 0);
    run_frame(24'h0F_00_00, 2'd1, 1'b0, 875);

    // Random commands against the width model.
    for (int k = 0; k < 6; k++) begin
      rd = 24'($urandom);
      rl = 2'($urandom_range(1, 3));
      run_frame(rd, rl, 1'b0, (32 * int'(rl) + 3) * C);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/joybus_tx.md
Name: joybus_tx

Overview:
- Console-side JOYBUS transmitter. Serializes a 1–3 byte command (e.g. 0x00 info, 0x01 poll, 0x02/0x03 accessory read/write header) onto the single-wire line, then sends the console stop bit.
- Sits beside JOYBUS_rx on the same pin. The top level drives open-drain from JB_TX (0 = pull low, 1 = release).
- After tx_done the line is free for the controller reply, which JOYBUS_rx captures.

Parameters:
- CLK_PER_US, 25: clock cycles per 1 µs quarter-bit. 25 MHz system clock gives 25.
- MAX_BYTES, 3: maximum command length in bytes; sets tx_data width to 8*MAX_BYTES.

Ports:
- clk  input  1  system clock
- rst  input  1  reset: one clock; reset is synchronous and active-high
- tx_start  input  1  one-cycle request; sampled only in IDLE
- tx_data  input  24  command bytes, MSB-first; byte 0 = [23:16], byte 1 = [15:8], byte 2 = [7:0]
- tx_len  input  2  number of bytes to send (1–3); 0 = no transmission
- JB_TX  output  1  line drive: 1 = released/high, 0 = low
- tx_busy  output  1  high from the cycle after an accepted tx_start through the last stop-bit cycle
- tx_done  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset values: JB_TX=1, tx_busy=0, tx_done=0, state=IDLE, all counters 0. Reset mid-frame aborts the frame: JB_TX=1 on the next edge and no tx_done pulse.
- Timing unit: one quarter = CLK_PER_US cycles; one data bit = 4 quarters.
  - bit 0: low 3 quarters, then high 1 quarter.
  - bit 1: low 1 quarter, then high 3 quarters.
  - stop: low 1 quarter, then high 2 quarters.
- Capture: on tx_start=1 in IDLE with tx_len≠0, latch tx_data into a shift register and tx_len into a byte counter.
  - tx_start with tx_len=0 is ignored.
  - tx_start while busy is ignored; latched data stays stable.
- Latency: JB_TX goes 0 on the first edge after the accepted tx_start (registered output, no combinational path from inputs).
- FSM states: IDLE, BIT_LOW, BIT_HIGH, STOP_LOW, STOP_HIGH.
  - IDLE → BIT_LOW on an accepted start.
  - BIT_LOW → BIT_HIGH after (cur_bit ? 1 : 3) quarters.
  - BIT_HIGH → BIT_LOW after (cur_bit ? 3 : 1) quarters, when bits remain.
  - BIT_HIGH → STOP_LOW after 8*tx_len bits.
  - STOP_LOW → STOP_HIGH after 1 quarter.
  - STOP_HIGH → IDLE after 2 quarters; tx_done=1 for exactly that transition cycle.
- Counters:
  - cycle counter 0..CLK_PER_US-1, wraps and generates a quarter tick.
  - quarter counter 0..3.
  - bit counter 0..23 (5 bits).
  - All counters clear on state entry.
- Frame length: exactly (32*tx_len + 3)*CLK_PER_US cycles from the first JB_TX low to tx_done.
- Back-to-back: tx_start in the same cycle as tx_done is ignored. A start in the first IDLE cycle is accepted.

Optional Feature:
- Macro JOYBUS_TX_RX_HANDOFF_EN.
- Defined: adds output rx_start (1 bit, reset 0), pulsed for one cycle coincident with tx_done, so JOYBUS_rx arms without top-level glue.
- Undefined: the port is absent, and the top level generates rx_start from tx_done.

Decomposition:
- Package joybus_pkg holds:
  - state enum typedef jb_tx_state_t.
  - command constants JB_CMD_INFO=8'h00, JB_CMD_POLL=8'h01, JB_CMD_READ=8'h02, JB_CMD_WRITE=8'h03, JB_CMD_RESET=8'hFF.
  - quarter counts Q_BIT0_LOW=3, Q_BIT1_LOW=1, Q_STOP_LOW=1, Q_STOP_HIGH=2.
- One sub-module, joybus_qtick: a parameterized quarter-tick counter with synchronous clear. JOYBUS_rx can share it.

Test Plan:
- Single byte: tx_data[23:16]=8'h01, tx_len=1, CLK_PER_US=25.
  - Low pulses of 75×7 then 25 cycles.
  - Stop: 25 low, then 50 high.
  - tx_done exactly 875 cycles after the first low edge; tx_busy high throughout.
- Three bytes: 24'h02_80_15, tx_len=3.
  - Bench decodes bits by low width (25 → 1, 75 → 0) and recovers 24'h028015.
  - Frame length 99*25 = 2475 cycles.
- Ignored starts: tx_start with tx_len=0 → JB_TX stays 1, no busy, no tx_done. A second tx_start during byte 0 with different data → transmitted bits unchanged.
- Reset mid-frame: assert rst during the bit-4 low phase → JB_TX=1 next edge, tx_busy=0, no tx_done. A new start afterwards transmits normally.
- Loopback: joybus_tx JB_TX wired to JOYBUS_rx JB_RX through a model controller replying 8'h05,8'h00,8'h02 plus stop.
  - With JOYBUS_TX_RX_HANDOFF_EN, rx_start pulses with tx_done.
  - rx_done rises; jb_cntlr_status=8'h05.
